// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-cell arbiter: datapath width,
// FSM state encoding and the partial-product recombination helper.
package mult_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COMBINE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Rebuild the low word of a*b from the three cell partial products.
  // The a.hi*b.hi term lands entirely above bit 31, so it is never needed.
  // Only the low 16 bits of the cross-term sum survive the shift, so the
  // sum may wrap at 32 bits without affecting the result.
  function automatic logic [DATA_W-1:0] combinePartials(
    input logic [DATA_W-1:0] pLoLo,
    input logic [DATA_W-1:0] pLoHi,
    input logic [DATA_W-1:0] pHiLo
  );
    logic [DATA_W-1:0] crossSum;
    crossSum = pLoHi + pHiLo;
    return pLoLo + (crossSum << 16);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Produces a one-hot grant; when both ports
// request, the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; contention is decided by the last winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mult_cell_arbiter.sv
// Shares one external pipelined multiplier cell between two requesters.
// One operation is in flight at a time: accept, issue to the cell, combine
// the partial products, then hold the response until it is taken.
module mult_cell_arbiter #(
  parameter int DATA_W = mult_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] mc_src1,
  output logic [DATA_W-1:0] mc_src2,
  output logic              mc_en,
  input  logic [DATA_W-1:0] mc_p1,
  input  logic [DATA_W-1:0] mc_p2,
  input  logic [DATA_W-1:0] mc_p3,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  import mult_pkg::*;

  state_e            state_q;
  logic              last_q;
  logic              rspId_q;
  logic              rspValid_q;
  logic              mcEn_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] rspData_q;
  logic [DATA_W-1:0] rspData_d;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;
  logic [CNT_W-1:0]  cnt0_d;
  logic [CNT_W-1:0]  cnt1_d;
  logic [1:0]        grant;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // Grants are only offered while idle and never while reset is held, so a
  // requester cannot see a handshake that the state registers will ignore.
  assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;

  // Next values for the result register and the per-port completion
  // counters; the counters wrap naturally at their width.
  always_comb begin
    rspData_d = combinePartials(mc_p1, mc_p2, mc_p3);
    cnt0_d    = cnt0_q + CNT_W'(1);
    cnt1_d    = cnt1_q + CNT_W'(1);
  end

  // Operation sequencer: every output except req_ready is a register, so
  // the cell and the consumer see glitch-free controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rspId_q    <= 1'b0;
      rspValid_q <= 1'b0;
      mcEn_q     <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      rspData_q  <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            src1_q  <= grant[1] ? req1_a : req0_a;
            src2_q  <= grant[1] ? req1_b : req0_b;
            rspId_q <= grant[1];
            last_q  <= grant[1];
            mcEn_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mcEn_q  <= 1'b0;
          state_q <= COMBINE;
        end
        COMBINE: begin
          rspData_q  <= rspData_d;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            if (rspId_q) begin
              cnt1_q <= cnt1_d;
            end else begin
              cnt0_q <= cnt0_d;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;
  assign mc_src1   = src1_q;
  assign mc_src2   = src2_q;
  assign mc_en     = mcEn_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Directed bench for mult_cell_arbiter, including a behavioural model of the
// external multiplier cell. The counters are narrowed to 4 bits here so the
// wrap-around case needs 16 handshakes instead of 65536.
module tb_mult_cell_arbiter;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [31:0]         req0_a, req0_b, req1_a, req1_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [31:0]         rsp_data;
  logic [31:0]         mc_src1, mc_src2;
  logic                mc_en;
  logic [31:0]         mc_p1 = '0;
  logic [31:0]         mc_p2 = '0;
  logic [31:0]         mc_p3 = '0;
  logic [TB_CNT_W-1:0] done_cnt0, done_cnt1;

  int compared   = 0;
  int mismatched = 0;

  mult_cell_arbiter #(
    .DATA_W (32),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .mc_src1   (mc_src1),
    .mc_src2   (mc_src2),
    .mc_en     (mc_en),
    .mc_p1     (mc_p1),
    .mc_p2     (mc_p2),
    .mc_p3     (mc_p3),
    .done_cnt0 (done_cnt0),
    .done_cnt1 (done_cnt1)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // One-stage multiplier cell: partial products appear the cycle after mc_en.
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= 32'(mc_src1[15:0]) * 32'(mc_src2[15:0]);
      mc_p2 <= 32'(mc_src1[15:0]) * 32'(mc_src2[31:16]);
      mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [31:0] a1,
                               input logic [31:0] b1);
    req_valid = valid;
    req0_a    = a0;
    req0_b    = b0;
    req1_a    = a1;
    req1_b    = b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(2'b11, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    tick();

    // Reset state, with both requesters valid to prove req_ready is held off.
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("rst_rsp_data",  rsp_data,       32'h0);
    checkOutput("rst_mc_en",     32'(mc_en),     32'h0);
    checkOutput("rst_mc_src1",   mc_src1,        32'h0);
    checkOutput("rst_mc_src2",   mc_src2,        32'h0);
    checkOutput("rst_cnt0",      32'(done_cnt0), 32'h0);
    checkOutput("rst_cnt1",      32'(done_cnt1), 32'h0);

    // Port 0 single operation: 0x12345 * 0x10.
    reset = 1'b0;
    applyStimulus(2'b01, 32'h0001_2345, 32'h0000_0010, 32'h0, 32'h0);
    #1;
    checkOutput("p0_grant", 32'(req_ready), 32'h1);
    tick();
    checkOutput("p0_busy_ready", 32'(req_ready), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("p0_issue_en", 32'(mc_en), 32'h1);
    checkOutput("p0_src1",     mc_src1,    32'h0001_2345);
    checkOutput("p0_src2",     mc_src2,    32'h0000_0010);
    tick();
    checkOutput("p0_comb_en",    32'(mc_en),     32'h0);
    checkOutput("p0_comb_valid", 32'(rsp_valid), 32'h0);
    tick();
    checkOutput("p0_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("p0_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("p0_rsp_data",  rsp_data,       32'h0012_3450);
    checkOutput("p0_src1_held", mc_src1,        32'h0001_2345);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("p0_done_valid", 32'(rsp_valid), 32'h0);
    checkOutput("p0_cnt0",       32'(done_cnt0), 32'h1);
    checkOutput("p0_cnt1",       32'(done_cnt1), 32'h0);

    // Port 1 all-ones operands, then a stalled response with port 0 waiting.
    applyStimulus(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    checkOutput("p1_grant", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    applyStimulus(2'b01, 32'h0000_0011, 32'h0000_0022, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(rsp_valid), 32'h1);
      checkOutput("stall_id",    32'(rsp_id),    32'h1);
      checkOutput("stall_data",  rsp_data,       32'h0000_0001);
      checkOutput("stall_ready", 32'(req_ready), 32'h0);
      checkOutput("stall_mc_en", 32'(mc_en),     32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("p1_done_valid", 32'(rsp_valid), 32'h0);
    checkOutput("p1_cnt1",       32'(done_cnt1), 32'h1);
    checkOutput("p1_cnt0",       32'(done_cnt0), 32'h1);
    checkOutput("pending_grant", 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Sustained dual request right after reset alternates 0,1,0,1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, 32'd3, 32'd5, 32'd7, 32'd9);
    rsp_ready = 1'b1;
    #1;
    checkOutput("rr_first_grant", 32'(req_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      tick();
      checkOutput("rr_valid", 32'(rsp_valid), 32'h1);
      checkOutput("rr_id",    32'(rsp_id),    32'(k % 2));
      checkOutput("rr_data",  rsp_data,       (k % 2 == 1) ? 32'd63 : 32'd15);
      tick();
      checkOutput("rr_next_grant", 32'(req_ready), (k % 2 == 1) ? 32'h1 : 32'h2);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rsp_ready = 1'b0;
    checkOutput("rr_cnt0", 32'(done_cnt0), 32'h2);
    checkOutput("rr_cnt1", 32'(done_cnt1), 32'h2);

    // Reset pulse while in COMBINE discards the operation.
    applyStimulus(2'b01, 32'h0001_2345, 32'h0000_0010, 32'h0, 32'h0);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'h0);
    checkOutput("mid_rst_mc_en", 32'(mc_en),     32'h0);
    checkOutput("mid_rst_src1",  mc_src1,        32'h0);
    checkOutput("mid_rst_src2",  mc_src2,        32'h0);
    checkOutput("mid_rst_data",  rsp_data,       32'h0);
    checkOutput("mid_rst_id",    32'(rsp_id),    32'h0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    checkOutput("mid_rst_cnt0",  32'(done_cnt0), 32'h0);
    checkOutput("mid_rst_cnt1",  32'(done_cnt1), 32'h0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("post_rst_valid", 32'(rsp_valid), 32'h0);
    checkOutput("post_rst_cnt0",  32'(done_cnt0), 32'h0);
    checkOutput("post_rst_cnt1",  32'(done_cnt1), 32'h0);

    // A fresh request after the aborted one completes normally.
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h0001_0003, 32'h0002_0001);
    #1;
    checkOutput("after_rst_grant", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("after_rst_valid", 32'(rsp_valid), 32'h1);
    checkOutput("after_rst_id",    32'(rsp_id),    32'h1);
    checkOutput("after_rst_data",  rsp_data,       32'h0007_0003);
    rsp_ready = 1'b1;
    tick();
    checkOutput("after_rst_cnt1", 32'(done_cnt1), 32'h1);
    checkOutput("after_rst_cnt0", 32'(done_cnt0), 32'h0);

    // Port 0 counter wraps after 2^CNT_W handshakes; port 1 is untouched.
    applyStimulus(2'b01, 32'h0001_2345, 32'h0000_0010, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      tick();
      checkOutput("wrap_rsp_id", 32'(rsp_id), 32'h0);
      tick();
      checkOutput("wrap_cnt0", 32'(done_cnt0), 32'((i + 1) % 16));
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rsp_ready = 1'b0;
    checkOutput("wrap_cnt1", 32'(done_cnt1), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
